// File: rtl/rs_collapse_station.sv
// rs_collapse_station
//   Age-ordered, collapsing reservation station feeding one functional unit.
//   Entry 0 is always the oldest. Entries hold operand values or the ROB tag of
//   the producer, snoop the CDB for wakeup, and the oldest entry with both
//   operands ready is moved into a single issue register. The issue register
//   talks to the unit over a valid/ready handshake.
//
// Ports
//   clk1, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                  synchronous squash of all entries and the issue reg
//   disp_*                 dispatch request (valid/ready, opcode, dest ROB,
//                          per-operand ready flag, value and producer tag)
//   cdb_valid/tag/data     common data bus broadcast
//   iss_*                  issue register towards the functional unit
//   occupancy              entries held, excluding the issue register
module rs_collapse_station #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ROB_W  = 3,
  parameter int FUNC_W = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [FUNC_W-1:0] disp_func,
  input  logic [ROB_W-1:0]  disp_rob,
  input  logic              disp_s1_rdy,
  input  logic              disp_s2_rdy,
  input  logic [DATA_W-1:0] disp_s1_val,
  input  logic [DATA_W-1:0] disp_s2_val,
  input  logic [ROB_W-1:0]  disp_s1_tag,
  input  logic [ROB_W-1:0]  disp_s2_tag,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [FUNC_W-1:0] iss_func,
  output logic [ROB_W-1:0]  iss_rob,
  output logic [DATA_W-1:0] iss_s1,
  output logic [DATA_W-1:0] iss_s2,
  output logic [CNT_W-1:0]  occupancy
);

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [ROB_W-1:0]  rob;
    logic              r1;
    logic              r2;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [ROB_W-1:0]  t1;
    logic [ROB_W-1:0]  t2;
  } ent_t;

  ent_t              ent_q [DEPTH];
  ent_t              ent_d [DEPTH];
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              iss_valid_q, iss_valid_d;
  logic [FUNC_W-1:0] iss_func_q, iss_func_d;
  logic [ROB_W-1:0]  iss_rob_q, iss_rob_d;
  logic [DATA_W-1:0] iss_s1_q, iss_s1_d;
  logic [DATA_W-1:0] iss_s2_q, iss_s2_d;

  logic              load;
  logic              found;
  logic [CNT_W-1:0]  sel;
  ent_t              sel_ent;
  ent_t              new_ent;
  logic              do_accept;
  logic              do_remove;
  logic [CNT_W-1:0]  wr_idx;

  // Ready depends only on the registered count; a same-cycle issue never
  // opens a slot for a same-cycle dispatch.
  assign disp_ready = (occ_q < CNT_W'(DEPTH));
  assign occupancy  = occ_q;
  assign iss_valid  = iss_valid_q;
  assign iss_func   = iss_func_q;
  assign iss_rob    = iss_rob_q;
  assign iss_s1     = iss_s1_q;
  assign iss_s2     = iss_s2_q;

  // Stage boundary: select / collapse / wakeup / insert, all from registered state
  always_comb begin
    load      = !iss_valid_q || iss_ready;
    found     = 1'b0;
    sel       = '0;
    sel_ent   = ent_q[0];
    // Scan downward so the lowest (oldest) ready index wins. Readiness comes
    // from registered flags only, so a CDB wakeup issues one cycle later.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < occ_q) && ent_q[i].r1 && ent_q[i].r2) begin
        found   = 1'b1;
        sel     = CNT_W'(i);
        sel_ent = ent_q[i];
      end
    end
    do_remove = load && found;
    do_accept = disp_valid && disp_ready;
    // New entry goes behind everything that survives this cycle.
    wr_idx    = occ_q - CNT_W'(do_remove);

    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (do_remove && (CNT_W'(i) >= sel)) begin
        ent_d[i] = ent_q[i + 1];
      end
    end
    // Slots beyond the occupancy may hold stale tags; waking them is harmless
    // because they are overwritten on insert before ever being selected.
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && !ent_d[i].r1 && (ent_d[i].t1 == cdb_tag)) begin
        ent_d[i].r1 = 1'b1;
        ent_d[i].v1 = cdb_data;
      end
      if (cdb_valid && !ent_d[i].r2 && (ent_d[i].t2 == cdb_tag)) begin
        ent_d[i].r2 = 1'b1;
        ent_d[i].v2 = cdb_data;
      end
    end

    // Dispatch-time bypass catches a result broadcast in the dispatch cycle.
    new_ent.func = disp_func;
    new_ent.rob  = disp_rob;
    new_ent.t1   = disp_s1_tag;
    new_ent.t2   = disp_s2_tag;
    new_ent.r1   = disp_s1_rdy;
    new_ent.v1   = disp_s1_val;
    new_ent.r2   = disp_s2_rdy;
    new_ent.v2   = disp_s2_val;
    if (!disp_s1_rdy && cdb_valid && (disp_s1_tag == cdb_tag)) begin
      new_ent.r1 = 1'b1;
      new_ent.v1 = cdb_data;
    end
    if (!disp_s2_rdy && cdb_valid && (disp_s2_tag == cdb_tag)) begin
      new_ent.r2 = 1'b1;
      new_ent.v2 = cdb_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (do_accept && (CNT_W'(i) == wr_idx)) begin
        ent_d[i] = new_ent;
      end
    end

    occ_d       = occ_q + CNT_W'(do_accept) - CNT_W'(do_remove);
    iss_valid_d = iss_valid_q;
    iss_func_d  = iss_func_q;
    iss_rob_d   = iss_rob_q;
    iss_s1_d    = iss_s1_q;
    iss_s2_d    = iss_s2_q;
    if (load) begin
      iss_valid_d = found;
      if (found) begin
        iss_func_d = sel_ent.func;
        iss_rob_d  = sel_ent.rob;
        iss_s1_d   = sel_ent.v1;
        iss_s2_d   = sel_ent.v2;
      end
    end
    // Flush dominates: occupancy 0 invalidates every entry.
    if (flush) begin
      occ_d       = '0;
      iss_valid_d = 1'b0;
    end
  end

  // Stage boundary: control and issue register
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_func_q  <= '0;
      iss_rob_q   <= '0;
      iss_s1_q    <= '0;
      iss_s2_q    <= '0;
    end else begin
      occ_q       <= occ_d;
      iss_valid_q <= iss_valid_d;
      iss_func_q  <= iss_func_d;
      iss_rob_q   <= iss_rob_d;
      iss_s1_q    <= iss_s1_d;
      iss_s2_q    <= iss_s2_d;
    end
  end

  // Stage boundary: entry storage (validity is carried by occ_q)
  always_ff @(posedge clk1) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_rs_collapse_station.sv
module tb_rs_collapse_station;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ROB_W  = 3;
  localparam int FUNC_W = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [FUNC_W-1:0] disp_func;
  logic [ROB_W-1:0]  disp_rob;
  logic              disp_s1_rdy, disp_s2_rdy;
  logic [DATA_W-1:0] disp_s1_val, disp_s2_val;
  logic [ROB_W-1:0]  disp_s1_tag, disp_s2_tag;
  logic              cdb_valid;
  logic [ROB_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              iss_valid;
  logic              iss_ready;
  logic [FUNC_W-1:0] iss_func;
  logic [ROB_W-1:0]  iss_rob;
  logic [DATA_W-1:0] iss_s1, iss_s2;
  logic [CNT_W-1:0]  occupancy;

  int tests = 0;
  int fails = 0;

  rs_collapse_station #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .FUNC_W(FUNC_W), .CNT_W(CNT_W)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_func(disp_func), .disp_rob(disp_rob),
    .disp_s1_rdy(disp_s1_rdy), .disp_s2_rdy(disp_s2_rdy),
    .disp_s1_val(disp_s1_val), .disp_s2_val(disp_s2_val),
    .disp_s1_tag(disp_s1_tag), .disp_s2_tag(disp_s2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_func(iss_func), .iss_rob(iss_rob),
    .iss_s1(iss_s1), .iss_s2(iss_s2),
    .occupancy(occupancy)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic set_disp(input logic [FUNC_W-1:0] f, input logic [ROB_W-1:0] rob,
                          input logic r1, input logic [DATA_W-1:0] v1, input logic [ROB_W-1:0] t1,
                          input logic r2, input logic [DATA_W-1:0] v2, input logic [ROB_W-1:0] t2);
    disp_valid  = 1'b1;
    disp_func   = f;
    disp_rob    = rob;
    disp_s1_rdy = r1;
    disp_s1_val = v1;
    disp_s1_tag = t1;
    disp_s2_rdy = r2;
    disp_s2_val = v2;
    disp_s2_tag = t2;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_func = '0; disp_rob = '0;
    disp_s1_rdy = 1'b0; disp_s2_rdy = 1'b0; disp_s1_val = '0; disp_s2_val = '0;
    disp_s1_tag = '0; disp_s2_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    iss_ready = 1'b1;

    // Reset state
    #2;
    check("rst_occ", occupancy, 0);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_iss_s1", iss_s1, 0);
    check("rst_iss_rob", iss_rob, 0);
    #1 rst_n = 1'b1;
    tick();

    // Single ready op: one-cycle dispatch-to-issue
    set_disp(4'd0, 3'd2, 1'b1, 16'd5, 3'd0, 1'b1, 16'd7, 3'd0);
    tick();
    disp_valid = 1'b0;
    check("t1_occ_after_disp", occupancy, 1);
    check("t1_iss_valid_early", iss_valid, 0);
    tick();
    check("t1_iss_valid", iss_valid, 1);
    check("t1_iss_s1", iss_s1, 5);
    check("t1_iss_s2", iss_s2, 7);
    check("t1_iss_rob", iss_rob, 2);
    check("t1_occ", occupancy, 0);
    tick();
    check("t1_drain", iss_valid, 0);

    // Out-of-order issue: younger ready op overtakes waiting op
    set_disp(4'd1, 3'd1, 1'b0, 16'd0, 3'd4, 1'b1, 16'd1, 3'd0);
    tick();
    set_disp(4'd2, 3'd3, 1'b1, 16'd2, 3'd0, 1'b1, 16'd3, 3'd0);
    tick();
    disp_valid = 1'b0;
    check("t2_occ2", occupancy, 2);
    check("t2_none_ready", iss_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'd9;
    tick();
    cdb_valid = 1'b0;
    check("t2_first_valid", iss_valid, 1);
    check("t2_first_rob", iss_rob, 3);
    check("t2_first_func", iss_func, 2);
    check("t2_occ1", occupancy, 1);
    tick();
    check("t2_second_rob", iss_rob, 1);
    check("t2_second_s1", iss_s1, 9);
    check("t2_second_s2", iss_s2, 1);
    check("t2_occ0", occupancy, 0);
    tick();
    check("t2_drain", iss_valid, 0);

    // Dispatch-time CDB bypass
    set_disp(4'd3, 3'd5, 1'b1, 16'd1, 3'd0, 1'b0, 16'd0, 3'd6);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h00AA;
    tick();
    disp_valid = 1'b0; cdb_valid = 1'b0;
    check("t3_occ", occupancy, 1);
    tick();
    check("t3_iss_valid", iss_valid, 1);
    check("t3_iss_rob", iss_rob, 5);
    check("t3_iss_s2", iss_s2, 16'h00AA);
    tick();
    check("t3_drain", iss_valid, 0);

    // Fill to DEPTH with waiting ops, reject 5th, wake entry 2
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(4'd4, 3'(i), 1'b0, 16'd0, 3'(i + 4), 1'b1, 16'(16 + i), 3'd0);
      tick();
    end
    check("t4_full_occ", occupancy, 4);
    check("t4_full_ready", disp_ready, 0);
    set_disp(4'd5, 3'd4, 1'b1, 16'd1, 3'd0, 1'b1, 16'd1, 3'd0);
    tick();
    disp_valid = 1'b0;
    check("t4_reject_occ", occupancy, 4);
    check("t4_reject_iss", iss_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h0033;
    tick();
    cdb_valid = 1'b0;
    check("t4_wake_no_issue", iss_valid, 0);
    tick();
    check("t4_iss_valid", iss_valid, 1);
    check("t4_iss_rob", iss_rob, 2);
    check("t4_iss_s1", iss_s1, 16'h0033);
    check("t4_iss_s2", iss_s2, 18);
    check("t4_occ", occupancy, 3);
    check("t4_ready_back", disp_ready, 1);

    // Hold while unit stalls, then load next oldest ready
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h0044;
    tick();
    cdb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_hold_valid", iss_valid, 1);
      check("t5_hold_rob", iss_rob, 2);
      check("t5_hold_s1", iss_s1, 16'h0033);
      if (i < 2) tick();
    end
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    check("t5_next_rob", iss_rob, 0);
    check("t5_next_s1", iss_s1, 16'h0044);
    check("t5_next_s2", iss_s2, 16);
    check("t5_occ", occupancy, 2);

    // Flush with 3 entries, busy issue register and concurrent dispatch
    set_disp(4'd6, 3'd6, 1'b0, 16'd0, 3'd1, 1'b1, 16'd0, 3'd0);
    tick();
    check("t6_pre_occ", occupancy, 3);
    check("t6_pre_iss", iss_valid, 1);
    set_disp(4'd7, 3'd7, 1'b1, 16'd1, 3'd0, 1'b1, 16'd2, 3'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0; disp_valid = 1'b0;
    check("t6_flush_occ", occupancy, 0);
    check("t6_flush_iss", iss_valid, 0);
    iss_ready = 1'b1;
    tick();
    check("t6_dropped_iss", iss_valid, 0);
    check("t6_dropped_occ", occupancy, 0);

    // Same scenario, killed by async reset mid-cycle
    iss_ready = 1'b0;
    set_disp(4'd1, 3'd1, 1'b1, 16'd11, 3'd0, 1'b1, 16'd12, 3'd0);
    tick();
    disp_valid = 1'b0;
    tick();
    check("t7_pre_iss_rob", iss_rob, 1);
    for (int i = 0; i < 3; i++) begin
      set_disp(4'd2, 3'(i + 2), 1'b0, 16'd0, 3'd2, 1'b0, 16'd0, 3'd3);
      tick();
    end
    disp_valid = 1'b0;
    check("t7_pre_occ", occupancy, 3);
    check("t7_pre_iss", iss_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_occ", occupancy, 0);
    check("t7_rst_iss", iss_valid, 0);
    check("t7_rst_rob", iss_rob, 0);
    check("t7_rst_s1", iss_s1, 0);
    check("t7_rst_ready", disp_ready, 1);
    #1 rst_n = 1'b1;
    tick();
    check("t7_post_occ", occupancy, 0);
    check("t7_post_iss", iss_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
